fault_mem_cfg: RTL



---
 rtl/fault_mem_pkg.sv | 22 ++
 rtl/fault_site_eval.sv | 45 ++++
 rtl/fault_mem_cfg.sv | 107 ++++++++++
 3 files changed

// File: rtl/fault_mem_pkg.sv
// fault_mem_pkg: fault type codes, fault-table entry layout and width helpers
package fault_mem_pkg;
  localparam logic [2:0] FT_NONE   = 3'd0;
  localparam logic [2:0] FT_SA0    = 3'd1;
  localparam logic [2:0] FT_SA1    = 3'd2;
  localparam logic [2:0] FT_TF_UP  = 3'd3;
  localparam logic [2:0] FT_TF_DN  = 3'd4;
  localparam logic [2:0] FT_CF_INV = 3'd5;
  localparam logic [2:0] FT_NPSF   = 3'd6;
  localparam int MAX_AW = 16;
  localparam int MAX_BW = 8;
  typedef struct packed {
    logic [2:0]        ftype;
    logic [MAX_AW-1:0] vaddr;
    logic [MAX_BW-1:0] vbit;
    logic [MAX_AW-1:0] aaddr;
    logic [MAX_BW-1:0] abit;
  } fault_cfg_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fault_site_eval.sv
// fault_site_eval: decides whether one fault-table entry owns its victim bit this op and what value it leaves
module fault_site_eval import fault_mem_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int CAPACITY   = 64
) (
  input  fault_cfg_t            i_cfg,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_vic_old,
  input  logic                  i_nb_hi,
  input  logic                  i_nb_lo,
  input  logic [DATA_WIDTH-1:0] i_agg_old,
  input  logic [DATA_WIDTH-1:0] i_agg_new,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_mask,
  output logic                  o_val,
  output logic                  o_hit
);
  localparam int BW = idx_w(DATA_WIDTH);
  logic [BW-1:0] w_vb, w_ab;
  logic w_ok, w_at_v, w_agg_up, w_old, w_new, w_base, w_act;
  assign w_vb     = i_cfg.vbit[BW-1:0];
  assign w_ab     = i_cfg.abit[BW-1:0];
  assign w_ok     = i_en && i_cfg.vbit < MAX_BW'(DATA_WIDTH) && i_cfg.vaddr < MAX_AW'(CAPACITY);
  assign w_at_v   = w_ok && MAX_AW'(i_addr) == i_cfg.vaddr;
  assign w_agg_up = w_ok && i_we && i_cfg.abit < MAX_BW'(DATA_WIDTH) && MAX_AW'(i_addr) == i_cfg.aaddr
                    && !i_agg_old[w_ab] && i_agg_new[w_ab];
  assign w_old    = i_vic_old[w_vb];
  assign w_new    = i_wdata[w_vb];
  // fault-free victim bit after this op; a same-word write lands first so coupling inverts the new data
  assign w_base   = (i_we && w_at_v) ? w_new : w_old;
  assign w_act    = (i_cfg.ftype == FT_SA0 || i_cfg.ftype == FT_SA1) ? w_at_v :
                    (i_cfg.ftype == FT_TF_UP || i_cfg.ftype == FT_TF_DN || i_cfg.ftype == FT_NPSF) ? (w_at_v && i_we) :
                    (i_cfg.ftype == FT_CF_INV) ? w_agg_up : 1'b0;
  assign o_val    = (i_cfg.ftype == FT_SA0)    ? 1'b0 :
                    (i_cfg.ftype == FT_SA1)    ? 1'b1 :
                    (i_cfg.ftype == FT_TF_UP)  ? (w_old & w_new) :
                    (i_cfg.ftype == FT_TF_DN)  ? (w_old | w_new) :
                    (i_cfg.ftype == FT_CF_INV) ? !w_base :
                    (i_cfg.ftype == FT_NPSF)   ? ((i_nb_hi && i_nb_lo) ? w_old : w_new) : w_base;
  assign o_mask   = w_act ? DATA_WIDTH'(1) << w_vb : '0;
  assign o_hit    = w_act && o_val != w_base;
endmodule

// File: rtl/fault_mem_cfg.sv
// fault_mem_cfg: pipelined word memory with a runtime-programmable table of injected faults and a hit counter
module fault_mem_cfg import fault_mem_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int CAPACITY   = 64,
  parameter int NUM_FAULTS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             write_read,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata,
  input  logic                             cfg_we,
  input  logic [idx_w(NUM_FAULTS)-1:0]     cfg_idx,
  input  logic [2:0]                       cfg_type,
  input  logic [ADDR_WIDTH-1:0]            cfg_vaddr,
  input  logic [idx_w(DATA_WIDTH)-1:0]     cfg_vbit,
  input  logic [ADDR_WIDTH-1:0]            cfg_aaddr,
  input  logic [idx_w(DATA_WIDTH)-1:0]     cfg_abit,
  output logic [CNT_WIDTH-1:0]             fault_hit_cnt
);
  localparam int AIW = idx_w(CAPACITY);
  localparam int BW  = idx_w(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] r_mem [CAPACITY];
  logic [DATA_WIDTH-1:0] w_mem [CAPACITY];
  fault_cfg_t            r_cfg [NUM_FAULTS];
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rd, w_rd;
  logic                  w_in, w_hit, w_own;
  logic [AIW-1:0]        w_ri;
  logic [AIW-1:0]        w_vi [NUM_FAULTS];
  logic [AIW-1:0]        w_ai [NUM_FAULTS];
  logic [BW-1:0]         w_bi [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] w_mask [NUM_FAULTS];
  logic [NUM_FAULTS-1:0] w_val, w_hit_e;
  assign w_in = MAX_AW'(r_addr) < MAX_AW'(CAPACITY);
  assign w_ri = w_in ? r_addr[AIW-1:0] : '0;
  for (genvar g = 0; g < NUM_FAULTS; g++) begin : g_site
    assign w_vi[g] = r_cfg[g].vaddr < MAX_AW'(CAPACITY) ? r_cfg[g].vaddr[AIW-1:0] : '0;
    assign w_ai[g] = r_cfg[g].aaddr < MAX_AW'(CAPACITY) ? r_cfg[g].aaddr[AIW-1:0] : '0;
    assign w_bi[g] = r_cfg[g].vbit < MAX_BW'(DATA_WIDTH) ? r_cfg[g].vbit[BW-1:0] : '0;
    fault_site_eval #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CAPACITY(CAPACITY)) u_site (
      .i_cfg(r_cfg[g]),
      .i_en(w_in),
      .i_we(r_we),
      .i_addr(r_addr),
      .i_vic_old(r_mem[w_vi[g]]),
      .i_nb_hi(r_mem[(w_vi[g] == AIW'(CAPACITY - 1)) ? AIW'(0) : w_vi[g] + 1'b1][w_bi[g]]),
      .i_nb_lo(r_mem[(w_vi[g] == AIW'(0)) ? AIW'(CAPACITY - 1) : w_vi[g] - 1'b1][w_bi[g]]),
      .i_agg_old(r_mem[w_ai[g]]),
      .i_agg_new(r_wdata),
      .i_wdata(r_wdata),
      .o_mask(w_mask[g]),
      .o_val(w_val[g]),
      .o_hit(w_hit_e[g])
    );
  end
  // next array image and read word: direct data first, then overrides with the lowest entry applied last
  always_comb begin
    w_mem = r_mem;
    w_rd  = w_in ? r_mem[w_ri] : '0;
    if (w_in && r_we) w_mem[w_ri] = r_wdata;
    for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
      if (r_we) w_mem[w_vi[i]] = (w_mem[w_vi[i]] & ~w_mask[i]) | (w_val[i] ? w_mask[i] : '0);
      else w_rd = (w_rd & ~w_mask[i]) | (w_val[i] ? w_mask[i] : '0);
    end
  end
  // an entry's hit only counts when no lower-index entry also claims the same victim bit
  always_comb begin
    w_hit = 1'b0;
    w_own = 1'b1;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      w_own = 1'b1;
      for (int j = 0; j < i; j++)
        if (w_vi[j] == w_vi[i] && (w_mask[j] & w_mask[i]) != '0) w_own = 1'b0;
      if (w_hit_e[i] && w_own) w_hit = 1'b1;
    end
  end
  // fault table: entries take effect for array ops from the next edge
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NUM_FAULTS; i++) r_cfg[i] <= '0;
    else if (cfg_we) r_cfg[cfg_idx] <= '{ftype: cfg_type, vaddr: MAX_AW'(cfg_vaddr), vbit: MAX_BW'(cfg_vbit),
                                         aaddr: MAX_AW'(cfg_aaddr), abit: MAX_BW'(cfg_abit)};
  // storage is unreset; a write in flight when reset arrives is dropped
  always_ff @(posedge clk)
    if (!rst) r_mem <= w_mem;
  // capture stage, array read stage, output stage and saturating hit counter
  always_ff @(posedge clk)
    if (rst) begin
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rd          <= '0;
      rdata         <= '0;
      fault_hit_cnt <= '0;
    end else begin
      r_we    <= write_read;
      r_addr  <= address;
      r_wdata <= wdata;
      if (!r_we) r_rd <= w_rd;
      rdata   <= r_rd;
      if (w_hit && !(&fault_hit_cnt)) fault_hit_cnt <= fault_hit_cnt + 1'b1;
    end
endmodule
